dmux_438: RTL and testbench
===========================

# dmux_438

Registered 1-to-2 demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the 4-bit 2:1 selector in the combinational-logic exercises. A single 4-bit source stream is steered by `sel` into one of two single-entry output holding registers, A or B. Each output channel drains independently to its consumer and counts the words it delivers. `enb` uses the same polarity as the selector: asserted high blocks the block and forces its outputs to 0000.

## Interface
- `CNT_W`, default 8: width of the per-channel delivered-word counters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enb`  in  1  active-high block/disable; 1 halts acceptance and masks outputs.
- `sel`  in  1  channel select: 0 routes to A, 1 routes to B.
- `din`  in  4  source data word.
- `din_vld`  in  1  source word valid.
- `din_rdy`  out  1  block accepts `din` this cycle.
- `A`  out  4  channel A data.
- `a_vld`  out  1  channel A holds a word.
- `a_rdy`  in  1  channel A consumer ready.
- `B`  out  4  channel B data.
- `b_vld`  out  1  channel B holds a word.
- `b_rdy`  in  1  channel B consumer ready.
- `cnt_a`  out  CNT_W  words delivered on A.
- `cnt_b`  out  CNT_W  words delivered on B.

## Operation
- State per channel: 4-bit data register plus `full` flag.
- Target channel: A when `sel`=0, B when `sel`=1. With `DMUX438_ALT_EN` defined, the target comes from the toggle described under Configuration.
- Accept: `din_vld` & `din_rdy` at a rising edge.
  - `din` loads into the target register.
  - The target's `full` flag sets.
- `din_rdy` = !`enb` & (!target.full | (target.full & target.rdy)).
  - `din_rdy` is combinational from `sel`, `enb`, `a_rdy` and `b_rdy`.
- Drain: x_vld & x_rdy at an edge.
  - Clears x.full, unless a new word loads into x in the same cycle; then x.full stays 1 and the new data replaces the old.
  - Increments cnt_x.
- A word is never loaded into a full channel that is not draining that cycle. No data loss, no duplication.
- The channels are independent:
  - A can drain while B loads.
  - Both can drain in the same cycle.
- `enb`=1:
  - `din_rdy`=0, `a_vld`=`b_vld`=0, `A`=`B`=4'b0000.
  - No drains and no counter changes.
  - Stored words and `full` flags are retained and reappear when `enb` returns to 0.
- Counters wrap from 2^CNT_W-1 to 0.

## Timing
- Reset values:
  - `A`=`B`=0000, `a_vld`=`b_vld`=0.
  - `cnt_a`=`cnt_b`=0, `full` flags 0, alternation toggle at A.
- `din_rdy` follows the combinational equation (1 while `enb`=0 and the target is empty).
- Latency: a word accepted at edge n is visible with x_vld=1 after edge n.
- Throughput: 1 word/cycle into a channel whose consumer holds rdy=1.
- `enb` masking is combinational on outputs. Internal state is frozen from the first edge at which `enb`=1 is sampled.
- Reset asserted mid-transfer: immediate clear of all state; held words are discarded.

## Configuration
- `DMUX438_ALT_EN` defined:
  - `sel` is ignored.
  - The target alternates A, B, A, B… via a toggle flip-flop that flips on each accepted word.
  - The toggle resets to A and holds while `enb`=1 or when nothing is accepted.
- Undefined: the target is `sel` only and no toggle flop exists.

## Test plan
- Reset asserted mid-transfer with A full: `A`=0000, `a_vld`=0, `cnt_a`=0 immediately; `din_rdy`=1 after release.
- `enb`=1, `sel`=0, `din`=0001, `din_vld`=1 → `din_rdy`=0, `A`=`B`=0000, vld low. Release `enb` → word accepted, `A`=0001, `a_vld`=1 next cycle.
- `sel`=0 word 0001, then `sel`=1 word 0010, `a_rdy`=`b_rdy`=1 → `A`=0001 then `B`=0010; `cnt_a`=1, `cnt_b`=1.
- `a_rdy`=0, two words 0011 and 0100 to A → first held, `din_rdy`=0 for the second. Raise `a_rdy` → 0011 drains, 0100 loads in the same cycle, `cnt_a` increments once.
- 256 words to A with `a_rdy`=1 → `cnt_a` wraps 255→0.
- `DMUX438_ALT_EN`: four words 0001..0100 with `sel` held at 1 → A gets 0001 and 0011, B gets 0010 and 0100.

Source files
------------

// File: rtl/dmux_438.sv
// Registered 1-to-2 demux with valid/ready handshakes and per-channel delivered-word counters.
// Optional feature: define DMUX438_ALT_EN to ignore sel and alternate targets A,B,A,B...
module dmux_438 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             sel,
  input  logic [3:0]       din,
  input  logic             din_vld,
  output logic             din_rdy,
  output logic [3:0]       A,
  output logic             a_vld,
  input  logic             a_rdy,
  output logic [3:0]       B,
  output logic             b_vld,
  input  logic             b_rdy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic [3:0]       a_data_q, a_data_d;
  logic [3:0]       b_data_q, b_data_d;
  logic             a_full_q, a_full_d;
  logic             b_full_q, b_full_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic target_b;
  logic a_drain, b_drain;
  logic tgt_full, tgt_drain;
  logic accept, load_a, load_b;

`ifdef DMUX438_ALT_EN
  logic tog_q, tog_d;

  assign target_b = tog_q;

  always_comb begin
    tog_d = tog_q;
    if (accept) tog_d = ~tog_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tog_q <= 1'b0;
    else     tog_q <= tog_d;
  end
`else
  assign target_b = sel;
`endif

  always_comb begin
    // enb freezes everything: no drains, no accepts, counters hold
    a_drain   = !enb && a_full_q && a_rdy;
    b_drain   = !enb && b_full_q && b_rdy;
    tgt_full  = target_b ? b_full_q : a_full_q;
    tgt_drain = target_b ? b_drain : a_drain;
    din_rdy   = !enb && (!tgt_full || tgt_drain);
    accept    = din_vld && din_rdy;
    load_a    = accept && !target_b;
    load_b    = accept && target_b;

    a_full_d = load_a || (a_full_q && !a_drain);
    b_full_d = load_b || (b_full_q && !b_drain);
    a_data_d = load_a ? din : a_data_q;
    b_data_d = load_b ? din : b_data_q;
    cnt_a_d  = a_drain ? cnt_a_q + 1'b1 : cnt_a_q;
    cnt_b_d  = b_drain ? cnt_b_q + 1'b1 : cnt_b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_data_q <= '0;
      b_data_q <= '0;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
    end else begin
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
    end
  end

  // Output masking by enb is purely combinational; stored state reappears on release.
  assign A     = enb ? 4'b0000 : a_data_q;
  assign B     = enb ? 4'b0000 : b_data_q;
  assign a_vld = !enb && a_full_q;
  assign b_vld = !enb && b_full_q;
  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;

endmodule

// File: tb/tb_dmux_438.sv
// Scoreboard bench for dmux_438: per-channel expected-word queues plus a reference model of flags and counters.
// Honours DMUX438_ALT_EN when defined for the build.
module tb_dmux_438;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enb = 1'b0;
  logic             sel = 1'b0;
  logic [3:0]       din = '0;
  logic             din_vld = 1'b0;
  logic             din_rdy;
  logic [3:0]       A, B;
  logic             a_vld, b_vld;
  logic             a_rdy = 1'b0;
  logic             b_rdy = 1'b0;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  logic [3:0]       qa[$];
  logic [3:0]       qb[$];
  logic             m_a_full = 1'b0;
  logic             m_b_full = 1'b0;
  logic             m_tog = 1'b0;
  logic [CNT_W-1:0] m_cnt_a = '0;
  logic [CNT_W-1:0] m_cnt_b = '0;

  dmux_438 #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enb(enb), .sel(sel), .din(din), .din_vld(din_vld),
    .din_rdy(din_rdy), .A(A), .a_vld(a_vld), .a_rdy(a_rdy), .B(B), .b_vld(b_vld),
    .b_rdy(b_rdy), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_a_full = 1'b0;
    m_b_full = 1'b0;
    m_tog    = 1'b0;
    m_cnt_a  = '0;
    m_cnt_b  = '0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, then step past the rising edge.
  task automatic cycle();
    logic tgt, dr_a, dr_b, rdy, acc;
    logic [3:0] e;
    @(negedge clk);
`ifdef DMUX438_ALT_EN
    tgt = m_tog;
`else
    tgt = sel;
`endif
    dr_a = !enb && m_a_full && a_rdy;
    dr_b = !enb && m_b_full && b_rdy;
    rdy  = !enb && (tgt ? (!m_b_full || dr_b) : (!m_a_full || dr_a));
    chk("din_rdy", din_rdy, rdy);
    chk("a_vld", a_vld, !enb && m_a_full);
    chk("b_vld", b_vld, !enb && m_b_full);
    chk("cnt_a", cnt_a, m_cnt_a);
    chk("cnt_b", cnt_b, m_cnt_b);
    if (enb) begin
      chk("A_masked", A, 4'b0000);
      chk("B_masked", B, 4'b0000);
    end
    if (dr_a) begin
      if (qa.size() == 0) chk("qa_nonempty", qa.size(), 1);
      else begin
        e = qa.pop_front();
        chk("A_data", A, e);
        $display("drain A data=%b cnt_a=%0d", A, cnt_a);
      end
      m_cnt_a = m_cnt_a + 1'b1;
      m_a_full = 1'b0;
    end
    if (dr_b) begin
      if (qb.size() == 0) chk("qb_nonempty", qb.size(), 1);
      else begin
        e = qb.pop_front();
        chk("B_data", B, e);
        $display("drain B data=%b cnt_b=%0d", B, cnt_b);
      end
      m_cnt_b = m_cnt_b + 1'b1;
      m_b_full = 1'b0;
    end
    acc = din_vld && rdy;
    if (acc) begin
      if (tgt) begin qb.push_back(din); m_b_full = 1'b1; end
      else     begin qa.push_back(din); m_a_full = 1'b1; end
      m_tog = ~m_tog;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic s, input logic [3:0] d,
                       input logic v, input logic ar, input logic br);
    enb = e; sel = s; din = d; din_vld = v; a_rdy = ar; b_rdy = br;
    cycle();
  endtask

  // Asynchronous reset in the middle of a clock phase; state must clear without an edge.
  task automatic reset_mid();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_A", A, 4'b0000);
    chk("rst_B", B, 4'b0000);
    chk("rst_a_vld", a_vld, 1'b0);
    chk("rst_b_vld", b_vld, 1'b0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CNT_W-1:0] c0;
    #3;
    chk("por_A", A, 4'b0000);
    chk("por_a_vld", a_vld, 1'b0);
    chk("por_b_vld", b_vld, 1'b0);
    chk("por_cnt_a", cnt_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // enb blocks then releases
    drive(1, 0, 4'b0001, 1, 1, 1);
    drive(1, 0, 4'b0001, 1, 1, 1);
    drive(0, 0, 4'b0001, 1, 1, 1);
    chk("enb_rel_A", A, 4'b0001);
    chk("enb_rel_a_vld", a_vld, 1'b1);
    drive(0, 0, 4'b0000, 0, 1, 1);

    // A then B
    drive(0, 0, 4'b0001, 1, 1, 1);
    drive(0, 1, 4'b0010, 1, 1, 1);
    drive(0, 0, 4'b0000, 0, 1, 1);
    drive(0, 0, 4'b0000, 0, 1, 1);

    // backpressure on A: second word waits, then drain and load in the same cycle
    drive(0, 0, 4'b0011, 1, 0, 1);
    drive(0, 0, 4'b0100, 1, 0, 1);
    drive(0, 0, 4'b0100, 1, 1, 1);
    drive(0, 0, 4'b0000, 0, 1, 1);
    drive(0, 0, 4'b0000, 0, 0, 0);

    // held words survive enb and reappear
    drive(0, 0, 4'b0101, 1, 0, 0);
    drive(0, 1, 4'b0110, 1, 0, 0);
    drive(1, 0, 4'b0111, 1, 1, 1);
    drive(1, 0, 4'b0111, 1, 1, 1);
    drive(0, 0, 4'b0000, 0, 0, 0);
    chk("held_A", A, 4'b0101);
    chk("held_B", B, 4'b0110);
    drive(0, 0, 4'b0000, 0, 1, 1);
    drive(0, 0, 4'b0000, 0, 1, 1);

    // counter wrap on A
    c0 = m_cnt_a;
    for (int i = 0; i < 256; i++) drive(0, 0, 4'(i), 1, 1, 1);
    drive(0, 0, 4'b0000, 0, 1, 1);
    drive(0, 0, 4'b0000, 0, 1, 1);
`ifdef DMUX438_ALT_EN
    chk("cnt_a_wrap", cnt_a, 32'(CNT_W'(c0 + 8'd128)));
`else
    chk("cnt_a_wrap", cnt_a, 32'(c0));
`endif

    // alternation from a fresh reset (plain routing in the default build)
    reset_mid();
    drive(0, 1, 4'b0001, 1, 1, 1);
`ifdef DMUX438_ALT_EN
    chk("alt_A1", A, 4'b0001);
`else
    chk("sel_B1", B, 4'b0001);
`endif
    drive(0, 1, 4'b0010, 1, 1, 1);
    drive(0, 1, 4'b0011, 1, 1, 1);
    drive(0, 1, 4'b0100, 1, 1, 1);
    drive(0, 1, 4'b0000, 0, 1, 1);
    drive(0, 1, 4'b0000, 0, 1, 1);

    // reset mid-transfer with A full
    drive(0, 0, 4'b1001, 1, 0, 0);
    drive(0, 0, 4'b0000, 0, 0, 0);
    reset_mid();
    chk("post_rst_din_rdy", din_rdy, 1'b1);
    drive(0, 0, 4'b0000, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
